// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, runtime thresholds, flush and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; otherwise reads are registered.
module sync_fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic [ADDR_WIDTH:0]   afull_thresh,
   input  logic [ADDR_WIDTH:0]   aempty_thresh,
   input  logic                  clr_err,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wptr;
   logic [ADDR_WIDTH:0]   rptr;
   logic                  wr_ok;
   logic                  rd_ok;

   // Handshake: a word enters when wr_en && !full, and leaves when rd_en && !empty;
   // flush overrides both. rd_valid qualifies rd_data towards the consumer.
   assign wr_ok = wr_en && !full && !flush;
   assign rd_ok = rd_en && !empty && !flush;

   // The extra pointer MSB separates full from empty once the pointers wrap.
   assign count        = wptr - rptr;
   assign full         = (count == DEPTH_L);
   assign empty        = (count == '0);
   assign almost_full  = (count >= afull_thresh);
   assign almost_empty = (count <= aempty_thresh);

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr[ADDR_WIDTH-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_ok) wptr <= wptr + 1'b1;
         if (rd_ok) rptr <= rptr + 1'b1;
      end
   end

   // Setting wins over clearing so an error in the clear cycle is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full) overflow <= 1'b1;
         else if (clr_err)  overflow <= 1'b0;
         if (rd_en && empty) underflow <= 1'b1;
         else if (clr_err)   underflow <= 1'b0;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rd_data  = mem[rptr[ADDR_WIDTH-1:0]];
   assign rd_valid = !empty;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_ok;
         if (rd_ok) rd_data <= mem[rptr[ADDR_WIDTH-1:0]];
      end
   end
`endif

endmodule
